// File: rtl/seq_stage_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | seq_stage_ctrl_if                                                          |
// | Datapath <-> sequencer bundle: decode fields, ALU flags, memory handshake. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seq_stage_ctrl_if;
  logic [3:0] icode;
  logic [3:0] ifun;
  logic       imem_error;
  logic       dmem_error;
  logic       mem_ack;
  logic       alu_zf;
  logic       alu_sf;
  logic       alu_of;
  logic       en_f;
  logic       en_d;
  logic       en_e;
  logic       en_m;
  logic       en_w;
  logic       en_pc;
  logic       mem_req;
  logic [2:0] cc;
  logic       cnd;
  logic [2:0] stat;

  modport master (
    input  icode, ifun, imem_error, dmem_error, mem_ack, alu_zf, alu_sf, alu_of,
    output en_f, en_d, en_e, en_m, en_w, en_pc, mem_req, cc, cnd, stat
  );

  modport slave (
    output icode, ifun, imem_error, dmem_error, mem_ack, alu_zf, alu_sf, alu_of,
    input  en_f, en_d, en_e, en_m, en_w, en_pc, mem_req, cc, cnd, stat
  );
endinterface

`default_nettype wire

// File: rtl/seq_stage_ctrl.sv
// +----------------------------------------------------------------------------+
// | seq_stage_ctrl                                                             |
// | Y86-64 SEQ multi-cycle sequencer: stage enables, CC register, cnd, stat.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_stage_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             start,
  seq_stage_ctrl_if.master      dp,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      retired_cnt
);

  localparam logic [2:0] C_STAT_AOK = 3'd1;
  localparam logic [2:0] C_STAT_HLT = 3'd2;
  localparam logic [2:0] C_STAT_ADR = 3'd3;
  localparam logic [2:0] C_STAT_INS = 3'd4;
  localparam int         WAIT_W     = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_MEMORY    = 4'd4,
    S_WRITEBACK = 4'd5,
    S_PCUPD     = 4'd6,
    S_HALT      = 4'd7,
    S_ERROR     = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        en_q, en_d;
  logic              mem_req_q, mem_req_d;
  logic [2:0]        cc_q, cc_d;
  logic              cnd_q, cnd_d;
  logic [2:0]        stat_q, stat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic w_zf, w_sf, w_of, w_lt, w_cond, w_bad_instr, w_mem_instr, w_active;

  assign w_zf = cc_q[2];
  assign w_sf = cc_q[1];
  assign w_of = cc_q[0];
  assign w_lt = w_sf ^ w_of;

  assign w_bad_instr = (dp.icode > 4'hB) ||
                       ((dp.icode == 4'h6) && (dp.ifun > 4'd3)) ||
                       (((dp.icode == 4'h2) || (dp.icode == 4'h7)) && (dp.ifun > 4'd6));

  assign w_mem_instr = (dp.icode == 4'h4) || (dp.icode == 4'h5) || (dp.icode == 4'h8) ||
                       (dp.icode == 4'h9) || (dp.icode == 4'hA) || (dp.icode == 4'hB);

  assign w_active = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);

  always_comb begin
    w_cond = 1'b0;
    case (dp.ifun)
      4'd0:    w_cond = 1'b1;
      4'd1:    w_cond = w_lt | w_zf;
      4'd2:    w_cond = w_lt;
      4'd3:    w_cond = w_zf;
      4'd4:    w_cond = ~w_zf;
      4'd5:    w_cond = ~w_lt;
      4'd6:    w_cond = ~w_lt & ~w_zf;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cc_d      = cc_q;
    cnd_d     = cnd_q;
    stat_d    = stat_q;
    wait_d    = wait_q;
    cycle_d   = cycle_q;
    retired_d = retired_q;

    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (dp.imem_error) begin
          state_d = S_ERROR;
          stat_d  = C_STAT_ADR;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_bad_instr) begin
          state_d = S_ERROR;
          stat_d  = C_STAT_INS;
        end else if (dp.icode == 4'h0) begin
          state_d = S_HALT;
          stat_d  = C_STAT_HLT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        // cnd sees the CCs from before this instruction's own update
        if (dp.icode == 4'h6) cc_d = {dp.alu_zf, dp.alu_sf, dp.alu_of};
        cnd_d   = ((dp.icode == 4'h2) || (dp.icode == 4'h7)) ? w_cond : 1'b0;
        wait_d  = '0;
        state_d = w_mem_instr ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        if (dp.mem_ack) begin
          state_d = dp.dmem_error ? S_ERROR : S_WRITEBACK;
          if (dp.dmem_error) stat_d = C_STAT_ADR;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d = S_ERROR;
          stat_d  = C_STAT_ADR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        if (retired_q != '1) retired_d = retired_q + 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    if (w_active && (cycle_q != '1)) cycle_d = cycle_q + 1'b1;

    // Outputs are registered from the next state so they line up with state_q
    en_d = {state_d == S_FETCH, state_d == S_DECODE, state_d == S_EXECUTE,
            state_d == S_MEMORY, state_d == S_WRITEBACK, state_d == S_PCUPD};
    mem_req_d = (state_d == S_MEMORY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      en_q      <= '0;
      mem_req_q <= 1'b0;
      cc_q      <= 3'b100;
      cnd_q     <= 1'b0;
      stat_q    <= C_STAT_AOK;
      wait_q    <= '0;
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mem_req_q <= mem_req_d;
      cc_q      <= cc_d;
      cnd_q     <= cnd_d;
      stat_q    <= stat_d;
      wait_q    <= wait_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
    end
  end

  assign dp.en_f      = en_q[5];
  assign dp.en_d      = en_q[4];
  assign dp.en_e      = en_q[3];
  assign dp.en_m      = en_q[2];
  assign dp.en_w      = en_q[1];
  assign dp.en_pc     = en_q[0];
  assign dp.mem_req   = mem_req_q;
  assign dp.cc        = cc_q;
  assign dp.cnd       = cnd_q;
  assign dp.stat      = stat_q;
  assign cycle_cnt    = cycle_q;
  assign retired_cnt  = retired_q;

endmodule

`default_nettype wire
